ifetch: RTL and testbench
=========================

Name: ifetch

Overview:
- Instruction fetch stage; the first pipeline stage, directly upstream of the decode stage.
- Masters a Wishbone-classic style 32-bit instruction bus and walks the PC.
- Assembles one-word (short) and two-word (long) instructions into a 64-bit instruction register for decode, with the matching PC.
- Honours the decode/pipeline stall and a PC redirect (branch/exception) from later stages.

Parameters:
RESET_VEC, 32'h0, byte address fetched first after reset
LONG_BIT, 0, bit of the first instruction word that marks a two-word instruction

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
stall_i  in  1  downstream stall; ir_o/pc_o must hold
pc_set_i  in  1  redirect request, one cycle pulse
pc_target_i  in  32  redirect byte address; bits [1:0] ignored
bus_cyc_o  out  1  bus cycle active
bus_stb_o  out  1  bus strobe
bus_adr_o  out  32  fetch byte address, bits [1:0] always 0
bus_ack_i  in  1  bus acknowledge, data valid
bus_dat_i  in  32  bus read data
ir_o  out  64  instruction to decode: [31:0] first word, [63:32] second word (0 for short)
pc_o  out  32  byte address following the presented instruction

Behaviour:
- Reset: rst_i asynchronous, active-high; clock clk_i.
- Reset values: ir_o=0, pc_o=0, bus_cyc_o=0, bus_stb_o=0, bus_adr_o=RESET_VEC, internal pc=RESET_VEC, state=FETCH1.
- ir_o=0 is a bubble (NOP) for decode.
- bus_cyc_o = bus_stb_o, asserted in FETCH1 and FETCH2; bus_adr_o = pc.
- FETCH1, ack with word[LONG_BIT]=0:
  - pc<=pc+4.
  - If !stall_i: ir_o<={32'h0,word}, pc_o<=pc+4, remain FETCH1.
  - Else: capture into buffer, go HOLD.
- FETCH1, ack with word[LONG_BIT]=1: save word as low half, pc<=pc+4, go FETCH2.
- FETCH2, ack: pc<=pc+4, instruction={word,low}. Present as in FETCH1 if !stall_i, else buffer and go HOLD.
- HOLD:
  - bus_cyc_o/bus_stb_o low.
  - When !stall_i: ir_o<=buffer, pc_o<=buffered pc, go FETCH1.
- Cycles in which no instruction is presented and !stall_i: ir_o<=0; pc_o holds.
- Whenever stall_i=1 (and no redirect): ir_o and pc_o hold their values.
- Throughput with zero-wait memory (ack in the same cycle as stb): one short instruction per clock, one long instruction per two clocks. Latency from ack to ir_o is one edge.
- Redirect (pc_set_i=1), highest priority, overrides stall_i and bus_ack_i:
  - pc<={pc_target_i[31:2],2'b00}, state<=FETCH1, buffer and partial low half discarded, ir_o<=0.
  - bus_cyc_o/bus_stb_o driven low in the cycle after pc_set_i (abort); fetch at the new pc starts the following cycle.
  - Any ack in the pc_set_i cycle is ignored.
- Wrap-around: pc increments modulo 2^32 (32'hFFFFFFFC+4 = 0). A long instruction whose second word wraps to address 0 is legal.
- Wait states: the stage holds stb and adr stable until ack. stall_i does not abort an outstanding access.
- Reset asserted mid-access: cycle dropped immediately; restart at RESET_VEC.

Test Plan:
- Reset release, zero-wait memory with short words 0x10000000, 0x20000000 at 0x0, 0x4:
  - bus_adr_o 0x0 then 0x4.
  - ir_o = 0x0000000010000000 with pc_o=0x4, then 0x0000000020000000 with pc_o=0x8, on consecutive edges.
- Long instruction: 0x0 holds 0x70000001, 0x4 holds 0xDEADBEEF:
  - ir_o = 0xDEADBEEF70000001, pc_o=0x8.
  - Exactly one bubble (ir_o=0) before it is presented.
- stall_i high for 3 cycles while a short word acks:
  - ir_o/pc_o hold the previous instruction; bus idle in HOLD.
  - On stall release the buffered word is presented; no word is lost or duplicated.
- pc_set_i with pc_target_i=0x103 while FETCH2 is waiting (ack late):
  - Next fetch address is 0x100.
  - Partial long instruction discarded; ir_o=0 after the redirect edge.
- pc_set_i and stall_i together, with ack in the same cycle:
  - ack ignored, ir_o=0, fetch resumes at target.
- RESET_VEC=32'hFFFFFFFC, long word there:
  - Second fetch at 0x0; pc_o=0x4.
- rst_i asserted mid-access:
  - bus_cyc_o and ir_o reach 0 asynchronously.
  - After release, first bus_adr_o=RESET_VEC.

Source files
------------

// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch - instruction fetch stage
//
// This is the first pipeline stage. It masters a Wishbone-classic style
// 32-bit instruction bus, walks the PC and builds one-word (short) or
// two-word (long) instructions into a 64-bit instruction register for
// decode. It honours a downstream stall and a PC redirect.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   stall_i      downstream stall; ir_o/pc_o hold while high
//   pc_set_i     redirect request (one-cycle pulse), beats stall and ack
//   pc_target_i  redirect byte address (bits [1:0] ignored)
//   bus_cyc_o    bus cycle active (same as bus_stb_o)
//   bus_stb_o    bus strobe
//   bus_adr_o    fetch byte address (word aligned)
//   bus_ack_i    bus acknowledge, bus_dat_i valid
//   bus_dat_i    bus read data
//   ir_o         instruction to decode: [31:0] first word, [63:32] second
//                word (0 for short); all-zero is a bubble
//   pc_o         byte address following the presented instruction
// ---------------------------------------------------------------------------
module ifetch #(
  parameter logic [31:0] RESET_VEC = 32'h0,
  parameter int          LONG_BIT  = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        pc_set_i,
  input  logic [31:0] pc_target_i,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic [31:0] bus_adr_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_dat_i,
  output logic [63:0] ir_o,
  output logic [31:0] pc_o
);

  typedef enum logic [1:0] {
    S_FETCH1 = 2'd0,
    S_FETCH2 = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  // r_abort keeps the bus idle for one cycle after a redirect or reset so
  // that an access interrupted mid-flight is visibly dropped.
  logic        r_abort;
  logic [31:0] r_pc;
  logic [31:0] r_low;
  logic [63:0] r_buf_ir;
  logic [31:0] r_buf_pc;

  logic        w_ack;
  logic        w_long;
  logic        w_present;
  logic [63:0] w_instr;
  logic [31:0] w_pc_inc;
  logic        w_unused;

  // An ack only counts while we are actually strobing.
  assign w_ack     = bus_ack_i & bus_stb_o;
  assign w_long    = bus_dat_i[LONG_BIT];
  assign w_present = w_ack & (((r_state == S_FETCH1) & ~w_long) |
                              (r_state == S_FETCH2));
  assign w_instr   = (r_state == S_FETCH2) ? {bus_dat_i, r_low}
                                           : {32'h0, bus_dat_i};
  assign w_pc_inc  = r_pc + 32'd4;
  assign bus_adr_o = r_pc;
  assign w_unused  = ^pc_target_i[1:0];

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_FETCH1;
      r_abort <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_abort <= pc_set_i;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH1: if (w_ack) begin
        if (w_long)       w_state_nxt = S_FETCH2;
        else if (stall_i) w_state_nxt = S_HOLD;
        else              w_state_nxt = S_FETCH1;
      end
      S_FETCH2: if (w_ack) w_state_nxt = stall_i ? S_HOLD : S_FETCH1;
      S_HOLD:   if (!stall_i) w_state_nxt = S_FETCH1;
      default:  w_state_nxt = S_FETCH1;
    endcase
    if (pc_set_i) w_state_nxt = S_FETCH1;
  end

  // Output logic
  always_comb begin
    bus_cyc_o = 1'b0;
    bus_stb_o = 1'b0;
    if (((r_state == S_FETCH1) || (r_state == S_FETCH2)) && !r_abort) begin
      bus_cyc_o = 1'b1;
      bus_stb_o = 1'b1;
    end
  end

  // PC, partial-instruction, stall buffer and decode-facing registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc     <= RESET_VEC;
      r_low    <= 32'h0;
      r_buf_ir <= 64'h0;
      r_buf_pc <= 32'h0;
      ir_o     <= 64'h0;
      pc_o     <= 32'h0;
    end else if (pc_set_i) begin
      r_pc     <= {pc_target_i[31:2], 2'b00};
      r_low    <= 32'h0;
      r_buf_ir <= 64'h0;
      r_buf_pc <= 32'h0;
      ir_o     <= 64'h0;
    end else begin
      if (w_ack) r_pc <= w_pc_inc;
      if (w_ack && (r_state == S_FETCH1) && w_long) r_low <= bus_dat_i;

      if (w_present) begin
        if (!stall_i) begin
          ir_o <= w_instr;
          pc_o <= w_pc_inc;
        end else begin
          r_buf_ir <= w_instr;
          r_buf_pc <= w_pc_inc;
        end
      end else if (!stall_i) begin
        // Release a buffered instruction, otherwise send a bubble.
        if (r_state == S_HOLD) begin
          ir_o <= r_buf_ir;
          pc_o <= r_buf_pc;
        end else begin
          ir_o <= 64'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        pc_set_i;
  logic [31:0] pc_target_i;
  logic        bus_cyc_o, bus_stb_o;
  logic [31:0] bus_adr_o;
  logic        bus_ack_i;
  logic [31:0] bus_dat_i;
  logic [63:0] ir_o;
  logic [31:0] pc_o;

  // second instance starting just below the top of the address space
  logic        w_cyc, w_stb;
  logic [31:0] w_adr;
  logic        w_ack;
  logic [31:0] w_dat;
  logic [63:0] w_ir;
  logic [31:0] w_pc;
  logic        w_stall = 1'b0;
  logic        w_set = 1'b0;
  logic [31:0] w_tgt = 32'h0;

  logic        ack_en;
  logic [31:0] mem [256];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk_i = ~clk_i;

  assign bus_ack_i = bus_stb_o & ack_en;
  assign bus_dat_i = mem[bus_adr_o[9:2]];
  assign w_ack     = w_stb;
  assign w_dat     = mem[w_adr[9:2]];

  ifetch #(.RESET_VEC(32'h0), .LONG_BIT(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .pc_set_i(pc_set_i),
    .pc_target_i(pc_target_i), .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o),
    .bus_adr_o(bus_adr_o), .bus_ack_i(bus_ack_i), .bus_dat_i(bus_dat_i),
    .ir_o(ir_o), .pc_o(pc_o)
  );

  ifetch #(.RESET_VEC(32'hFFFF_FFFC), .LONG_BIT(0)) dut_wrap (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(w_stall), .pc_set_i(w_set),
    .pc_target_i(w_tgt), .bus_cyc_o(w_cyc), .bus_stb_o(w_stb),
    .bus_adr_o(w_adr), .bus_ack_i(w_ack), .bus_dat_i(w_dat),
    .ir_o(w_ir), .pc_o(w_pc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'h1000_0000;
    mem[1]   = 32'h2000_0000;
    mem[2]   = 32'h7000_0001;
    mem[3]   = 32'hDEAD_BEEF;
    mem[4]   = 32'h3000_0000;
    mem[5]   = 32'h4000_0000;
    mem[6]   = 32'h5000_0001;
    mem[7]   = 32'hAAAA_AAA0;
    mem[64]  = 32'h6000_0000;
    mem[65]  = 32'h1111_1110;
    mem[128] = 32'h2222_2220;
    mem[255] = 32'h8000_0001;

    rst_i = 1'b1; stall_i = 1'b0; pc_set_i = 1'b0; pc_target_i = 32'h0; ack_en = 1'b1;
    #12;
    check("rst_ir", ir_o, 64'h0);
    check("rst_pc", {32'h0, pc_o}, 64'h0);
    check("rst_cyc", {63'h0, bus_cyc_o}, 64'h0);
    check("rst_adr", {32'h0, bus_adr_o}, 64'h0);
    check("rst_wrap_adr", {32'h0, w_adr}, 64'hFFFF_FFFC);
    rst_i = 1'b0;

    tick(); // idle cycle after reset
    check("fetch0_adr", {32'h0, bus_adr_o}, 64'h0);
    check("fetch0_stb", {63'h0, bus_stb_o}, 64'h1);
    check("wrap_adr0", {32'h0, w_adr}, 64'hFFFF_FFFC);
    tick();
    check("short1_ir", ir_o, 64'h0000_0000_1000_0000);
    check("short1_pc", {32'h0, pc_o}, 64'h4);
    check("fetch1_adr", {32'h0, bus_adr_o}, 64'h4);
    check("wrap_adr1", {32'h0, w_adr}, 64'h0);
    tick();
    check("short2_ir", ir_o, 64'h0000_0000_2000_0000);
    check("short2_pc", {32'h0, pc_o}, 64'h8);
    check("wrap_ir", w_ir, 64'h1000_0000_8000_0001);
    check("wrap_pc", {32'h0, w_pc}, 64'h4);
    tick();
    check("long_bubble", ir_o, 64'h0);
    check("long_adr2", {32'h0, bus_adr_o}, 64'hC);
    tick();
    check("long_ir", ir_o, 64'hDEAD_BEEF_7000_0001);
    check("long_pc", {32'h0, pc_o}, 64'h10);

    // stall for three edges while the short word at 0x10 acks
    stall_i = 1'b1;
    tick();
    check("stall1_ir", ir_o, 64'hDEAD_BEEF_7000_0001);
    check("stall1_pc", {32'h0, pc_o}, 64'h10);
    check("stall1_cyc", {63'h0, bus_cyc_o}, 64'h0);
    tick();
    check("stall2_ir", ir_o, 64'hDEAD_BEEF_7000_0001);
    check("stall2_cyc", {63'h0, bus_cyc_o}, 64'h0);
    tick();
    check("stall3_ir", ir_o, 64'hDEAD_BEEF_7000_0001);
    stall_i = 1'b0;
    tick();
    check("unstall_ir", ir_o, 64'h0000_0000_3000_0000);
    check("unstall_pc", {32'h0, pc_o}, 64'h14);
    check("unstall_adr", {32'h0, bus_adr_o}, 64'h14);
    tick();
    check("after_ir", ir_o, 64'h0000_0000_4000_0000);
    check("after_pc", {32'h0, pc_o}, 64'h18);

    // long at 0x18, second word delayed, then redirect to 0x103
    tick();
    check("redir_bubble", ir_o, 64'h0);
    check("redir_f2_adr", {32'h0, bus_adr_o}, 64'h1C);
    ack_en = 1'b0;
    tick();
    check("wait_adr", {32'h0, bus_adr_o}, 64'h1C);
    check("wait_stb", {63'h0, bus_stb_o}, 64'h1);
    pc_set_i = 1'b1; pc_target_i = 32'h0000_0103;
    tick();
    pc_set_i = 1'b0; ack_en = 1'b1;
    check("abort_cyc", {63'h0, bus_cyc_o}, 64'h0);
    check("abort_ir", ir_o, 64'h0);
    tick();
    check("target_adr", {32'h0, bus_adr_o}, 64'h100);
    check("target_cyc", {63'h0, bus_cyc_o}, 64'h1);
    tick();
    check("target_ir", ir_o, 64'h0000_0000_6000_0000);
    check("target_pc", {32'h0, pc_o}, 64'h104);

    // redirect and stall together, ack at 0x104 in the same cycle
    stall_i = 1'b1; pc_set_i = 1'b1; pc_target_i = 32'h0000_0200;
    tick();
    stall_i = 1'b0; pc_set_i = 1'b0;
    check("setstall_ir", ir_o, 64'h0);
    check("setstall_pc", {32'h0, pc_o}, 64'h104);
    check("setstall_cyc", {63'h0, bus_cyc_o}, 64'h0);
    tick();
    check("setstall_adr", {32'h0, bus_adr_o}, 64'h200);
    tick();
    check("setstall_res_ir", ir_o, 64'h0000_0000_2222_2220);
    check("setstall_res_pc", {32'h0, pc_o}, 64'h204);

    // outstanding access with stall held, then asynchronous reset
    ack_en = 1'b0; stall_i = 1'b1;
    tick();
    check("pend_cyc", {63'h0, bus_cyc_o}, 64'h1);
    check("pend_adr", {32'h0, bus_adr_o}, 64'h204);
    check("pend_ir", ir_o, 64'h0000_0000_2222_2220);
    #2 rst_i = 1'b1;
    #1;
    check("arst_cyc", {63'h0, bus_cyc_o}, 64'h0);
    check("arst_ir", ir_o, 64'h0);
    check("arst_adr", {32'h0, bus_adr_o}, 64'h0);
    #2 rst_i = 1'b0; stall_i = 1'b0; ack_en = 1'b1;
    tick();
    check("rerun_adr", {32'h0, bus_adr_o}, 64'h0);
    check("rerun_cyc", {63'h0, bus_cyc_o}, 64'h1);
    tick();
    check("rerun_ir", ir_o, 64'h0000_0000_1000_0000);
    check("rerun_pc", {32'h0, pc_o}, 64'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
